exec_datapath: RTL

//  Execute stage of the 4-bit uP, directly downstream of fetch/decode.

---
 rtl/exec_datapath.sv | 113 +++++++++++
 1 files changed

// File: rtl/exec_datapath.sv
// Execute stage of the 4-bit uP: accumulator, C/Z flags, data RAM, output latch,
// pushbutton synchronizer and the internal data-bus mux.
module exec_datapath #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadA,
  input  logic              loadFlags,
  input  logic [2:0]        opALU,
  input  logic              cs,
  input  logic              we,
  input  logic              oeALU,
  input  logic              oeIn,
  input  logic              oeOprnd,
  input  logic              loadOut,
  input  logic [DATA_W-1:0] oprnd,
  input  logic [ADDR_W-1:0] address_RAM,
  input  logic [DATA_W-1:0] pushbuttons,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] accu,
  output logic [DATA_W-1:0] FF_out,
  output logic              c_flag,
  output logic              z_flag,
  output logic              bus_err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [SYNC_N-1:0][DATA_W-1:0] syncQ;
  logic [DATA_W-1:0]             operandB;
  logic [DATA_W-1:0]             aluY;
  logic                          aluC;
  logic [DATA_W:0]               sum;
  logic                          ramRd;
  logic [2:0]                    drvCnt;

  assign ramRd = cs & ~we;

  // Non-ALU sources only, so the ALU never sees its own result through the bus.
  always_comb begin
    operandB = '0;
    if (oeOprnd)    operandB = oprnd;
    else if (oeIn)  operandB = syncQ[SYNC_N-1];
    else if (ramRd) operandB = mem[address_RAM];
  end

  always_comb begin
    aluY = '0;
    aluC = 1'b0;
    sum  = '0;
    case (opALU)
      OP_PASSA: aluY = accu;
      OP_SUB: begin
        // A + ~B + 1: carry out set means no borrow (A >= B).
        sum  = {1'b0, accu} + {1'b0, ~operandB} + (DATA_W+1)'(1);
        aluY = sum[DATA_W-1:0];
        aluC = sum[DATA_W];
      end
      OP_PASSB: aluY = operandB;
      OP_ADD: begin
        sum  = {1'b0, accu} + {1'b0, operandB};
        aluY = sum[DATA_W-1:0];
        aluC = sum[DATA_W];
      end
      OP_NAND: aluY = ~(accu & operandB);
      OP_AND:  aluY = accu & operandB;
      OP_OR:   aluY = accu | operandB;
      OP_XOR:  aluY = accu ^ operandB;
      default: aluY = '0;
    endcase
  end

  assign data_bus = oeALU ? aluY : operandB;

  assign drvCnt = 3'(oeALU) + 3'(oeOprnd) + 3'(oeIn) + 3'(ramRd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accu    <= '0;
      FF_out  <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      bus_err <= 1'b0;
      syncQ   <= '0;
    end else begin
      if (loadA)        accu <= aluY;
      if (loadFlags)    {c_flag, z_flag} <= {aluC, aluY == '0};
      if (loadOut)      FF_out <= data_bus;
      if (drvCnt > 3'd1) bus_err <= 1'b1;
      syncQ[0] <= pushbuttons;
      for (int i = 1; i < SYNC_N; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  // RAM is not reset; the write is gated by reset so a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && cs && we) mem[address_RAM] <= data_bus;
  end

endmodule
